// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment character arbiter.
//   - ASCII range constants for the displayable character set
//   - Pacer state encoding
//   - is_displayable(): true for '0'-'9', 'A'-'Z', 'a'-'z', '-' and '.'
package seg7_pkg;

    localparam logic [7:0] ASC_0    = 8'h30;
    localparam logic [7:0] ASC_9    = 8'h39;
    localparam logic [7:0] ASC_A    = 8'h41;
    localparam logic [7:0] ASC_Z    = 8'h5A;
    localparam logic [7:0] ASC_a    = 8'h61;
    localparam logic [7:0] ASC_z    = 8'h7A;
    localparam logic [7:0] ASC_DASH = 8'h2D;
    localparam logic [7:0] ASC_DOT  = 8'h2E;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } pacer_state_t;

    function automatic logic is_displayable(input logic [7:0] c);
        logic ok;
        ok = 1'b0;
        if ((c >= ASC_0) && (c <= ASC_9)) begin
            ok = 1'b1;
        end else if ((c >= ASC_A) && (c <= ASC_Z)) begin
            ok = 1'b1;
        end else if ((c >= ASC_a) && (c <= ASC_z)) begin
            ok = 1'b1;
        end else if ((c == ASC_DASH) || (c == ASC_DOT)) begin
            ok = 1'b1;
        end else begin
            ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/seg7_char_fifo.sv
// Synchronous 8-bit character FIFO.
//   clk, rst_n : clock, asynchronous active-low reset
//   wr_en, din : push din when not full and not flushing
//   rd_en      : pop the head when not empty and not flushing
//   flush      : synchronous empty (wins over push and pop)
//   dout       : current head entry (valid when !empty)
//   full, empty, count : occupancy status
// A full FIFO refuses writes even when a pop happens in the same cycle.
module seg7_char_fifo
    import seg7_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic                     rd_en,
    input  logic                     flush,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          do_wr_s;
    logic          do_rd_s;

    assign full    = (count_r == (AW+1)'(DEPTH));
    assign empty   = (count_r == (AW+1)'(0));
    assign count   = count_r;
    assign dout    = mem_r[rd_ptr_r];
    assign do_wr_s = wr_en & ~full & ~flush;
    assign do_rd_s = rd_en & ~empty & ~flush;

    // Storage array; pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (do_wr_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-2 depth).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_wr_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_rd_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_wr_s, do_rd_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/seg7_char_arbiter.sv
// Round-robin character arbiter and display pacer for the 8-digit 7-segment display.
//   clk, rst_n  : 1 MHz clock, asynchronous active-low reset
//   req_valid   : per-requester character valid
//   req_char    : per-requester ASCII char, requester i on bits [8i+7:8i]
//   req_ready   : per-requester accept (transfer on valid & ready)
//   clear_req   : level; flushes the queue and clears the display
//   char_out    : character presented to the display
//   char_valid  : character strobe, high PULSE_CYCLES, then low at least GAP_CYCLES+1
//   clear_out   : one-cycle clear pulse on each new clear_req assertion
//   busy        : queue non-empty or pacer not idle
//   fifo_count  : queue occupancy
// Optional build macro SEG7_ARB_FILTER_EN: non-displayable characters are still
// handshaked but not queued.
module seg7_char_arbiter
    import seg7_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int FIFO_DEPTH   = 8,
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [8*NUM_REQ-1:0]          req_char,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          clear_req,
    output logic [7:0]                    char_out,
    output logic                          char_valid,
    output logic                          clear_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int TMR_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam logic [TMR_W-1:0] PULSE_LAST = TMR_W'(PULSE_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LAST   = TMR_W'(GAP_CYCLES - 1);
    localparam logic [PTR_W-1:0] LAST_REQ   = PTR_W'(NUM_REQ - 1);

    pacer_state_t      state_r, state_next_s;
    logic [TMR_W-1:0]  tmr_r, tmr_next_s;
    logic [PTR_W-1:0]  rr_ptr_r;
    logic [7:0]        char_out_r, char_out_next_s;
    logic              char_valid_r, char_valid_next_s;
    logic              clear_out_r;
    logic              clear_d_r;
    logic              busy_r;

    logic [NUM_REQ-1:0] grant_s;
    logic [PTR_W-1:0]   grant_idx_s;
    logic               grant_found_s;
    int                 scan_idx_s;
    logic               accept_s;
    logic [7:0]         sel_char_s;
    logic               wr_en_s;
    logic               pop_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic [7:0]         fifo_dout_s;
    logic [CNT_W-1:0]   fifo_count_s;
    logic [CNT_W-1:0]   fifo_count_next_s;
    logic               busy_next_s;

    // Round-robin search starting at rr_ptr_r, wrapping past the last requester.
    always_comb begin
        grant_s       = '0;
        grant_idx_s   = '0;
        grant_found_s = 1'b0;
        scan_idx_s    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx_s = int'(rr_ptr_r) + k;
            if (scan_idx_s >= NUM_REQ) begin
                scan_idx_s = scan_idx_s - NUM_REQ;
            end else begin
                scan_idx_s = scan_idx_s;
            end
            if (!grant_found_s && req_valid[scan_idx_s]) begin
                grant_found_s         = 1'b1;
                grant_idx_s           = PTR_W'(scan_idx_s);
                grant_s[scan_idx_s]   = 1'b1;
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Clear blocks every accept, so a same-cycle push is refused.
    assign accept_s   = grant_found_s & ~fifo_full_s & ~clear_req;
    assign req_ready  = grant_s & {NUM_REQ{~fifo_full_s & ~clear_req}};
    assign sel_char_s = req_char[8*int'(grant_idx_s) +: 8];

`ifdef SEG7_ARB_FILTER_EN
    assign wr_en_s = accept_s & is_displayable(sel_char_s);
`else
    assign wr_en_s = accept_s;
`endif

    assign pop_s = (state_r == ST_IDLE) & ~fifo_empty_s & ~clear_req;

    seg7_char_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_en (wr_en_s),
        .rd_en (pop_s),
        .flush (clear_req),
        .din   (sel_char_s),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // Pacer next-state: clear forces a fresh gap; otherwise IDLE -> PULSE -> GAP -> IDLE.
    always_comb begin
        state_next_s      = state_r;
        tmr_next_s        = tmr_r;
        char_valid_next_s = char_valid_r;
        char_out_next_s   = char_out_r;
        if (clear_req) begin
            state_next_s      = ST_GAP;
            tmr_next_s        = '0;
            char_valid_next_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!fifo_empty_s) begin
                        char_out_next_s   = fifo_dout_s;
                        char_valid_next_s = 1'b1;
                        state_next_s      = ST_PULSE;
                        tmr_next_s        = '0;
                    end else begin
                        state_next_s      = ST_IDLE;
                    end
                end
                ST_PULSE: begin
                    if (tmr_r == PULSE_LAST) begin
                        char_valid_next_s = 1'b0;
                        state_next_s      = ST_GAP;
                        tmr_next_s        = '0;
                    end else begin
                        tmr_next_s        = tmr_r + TMR_W'(1);
                    end
                end
                ST_GAP: begin
                    if (tmr_r == GAP_LAST) begin
                        state_next_s      = ST_IDLE;
                        tmr_next_s        = '0;
                    end else begin
                        tmr_next_s        = tmr_r + TMR_W'(1);
                    end
                end
                default: begin
                    state_next_s      = ST_IDLE;
                    tmr_next_s        = '0;
                    char_valid_next_s = 1'b0;
                end
            endcase
        end
    end

    // busy is registered from next-cycle occupancy and state so it lines up with them.
    always_comb begin
        fifo_count_next_s = fifo_count_s;
        if (clear_req) begin
            fifo_count_next_s = '0;
        end else begin
            fifo_count_next_s = fifo_count_s + CNT_W'(wr_en_s) - CNT_W'(pop_s);
        end
        busy_next_s = (fifo_count_next_s != CNT_W'(0)) | (state_next_s != ST_IDLE);
    end

    // Pacer, arbiter pointer and clear edge-detect registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            tmr_r        <= '0;
            char_out_r   <= 8'h00;
            char_valid_r <= 1'b0;
            rr_ptr_r     <= '0;
            clear_d_r    <= 1'b0;
            clear_out_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            tmr_r        <= tmr_next_s;
            char_out_r   <= char_out_next_s;
            char_valid_r <= char_valid_next_s;
            clear_d_r    <= clear_req;
            clear_out_r  <= clear_req & ~clear_d_r;
            busy_r       <= busy_next_s;
            if (accept_s) begin
                rr_ptr_r <= (grant_idx_s == LAST_REQ) ? '0 : grant_idx_s + PTR_W'(1);
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
        end
    end

    assign char_out   = char_out_r;
    assign char_valid = char_valid_r;
    assign clear_out  = clear_out_r;
    assign busy       = busy_r;
    assign fifo_count = fifo_count_s;

endmodule
